// File: rtl/perf_snapshot_reader.sv
// perf_snapshot_reader: snapshots cycle/inst counters and streams framed delta records
module perf_snapshot_reader #(
    parameter int CYC_W  = 64,
    parameter int INST_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CYC_W-1:0]  cycle_count,
    input  logic [INST_W-1:0] inst_count,
    input  logic              snap_req,
    input  logic              clear_base,
    output logic              busy,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_data,
    output logic              out_last
);
    localparam int BEATS = 1 + CYC_W / 32 + INST_W / 32;
    localparam int REC_W = 32 * BEATS;
    localparam int IDX_W = $clog2(BEATS + 1);
    typedef enum logic {IDLE, SEND} state_t;
    state_t            state, state_n;
    logic [CYC_W-1:0]  base_cyc;
    logic [INST_W-1:0] base_inst;
    logic [15:0]       seq, seq_n;
    logic              dropped;
    logic [REC_W-1:0]  rec;
    logic [IDX_W-1:0]  idx;
    logic              accept, xfer, last;
    always_comb begin
        accept    = (state == IDLE) && snap_req;
        out_valid = (state == SEND);
        busy      = out_valid;
        xfer      = out_valid && out_ready;
        last      = idx == IDX_W'(BEATS - 1);
        out_last  = out_valid && last;
        out_data  = out_valid ? rec[31:0] : 32'd0;
        seq_n     = seq + 16'd1;
        state_n   = accept ? SEND : (xfer && last) ? IDLE : state;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else state <= state_n;
    end
    // The record is frozen at accept and shifted out LSW-first, so live counter motion never leaks in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base_cyc  <= '0;
            base_inst <= '0;
            seq       <= '0;
            dropped   <= 1'b0;
            rec       <= '0;
            idx       <= '0;
        end else begin
            if (accept) begin
                rec       <= {inst_count - base_inst, cycle_count - base_cyc, 8'hA5, 7'd0, dropped, seq_n};
                base_cyc  <= cycle_count;
                base_inst <= inst_count;
                seq       <= seq_n;
                dropped   <= 1'b0;
                idx       <= '0;
            end else if (state == IDLE && clear_base) begin
                base_cyc  <= cycle_count;
                base_inst <= inst_count;
            end
            if (state == SEND && snap_req) dropped <= 1'b1;
            if (xfer) begin
                rec <= rec >> 32;
                idx <= idx + IDX_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_perf_snapshot_reader.sv
// tb_perf_snapshot_reader: scoreboard bench for the perf counter snapshot reader
module tb_perf_snapshot_reader;
    logic        clk = 0, rst = 1, snap_req = 0, clear_base = 0, out_ready = 0;
    logic [63:0] cyc = 0, inst = 0;
    logic        busy, out_valid, out_last;
    logic [31:0] out_data;
    logic [63:0] m_base_cyc, m_base_inst;
    logic [15:0] m_seq;
    logic        m_drop;
    logic [32:0] exp_q[$], rx[$], e, a;
    int          n_cmp = 0, n_bad = 0, bc;
    bit          stable;

    perf_snapshot_reader #(.CYC_W(64), .INST_W(64)) dut (
        .clk(clk), .rst(rst), .cycle_count(cyc), .inst_count(inst), .snap_req(snap_req),
        .clear_base(clear_base), .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_base_cyc = 0; m_base_inst = 0; m_seq = 0; m_drop = 0; exp_q.delete(); rx.delete();
    endtask

    // Called at a negedge in IDLE: raise snap_req for one edge and predict the record.
    task automatic snap(input logic [63:0] c, input logic [63:0] i, input bit with_clear);
        logic [63:0] dc, di;
        cyc = c; inst = i; snap_req = 1; clear_base = with_clear;
        dc = c - m_base_cyc; di = i - m_base_inst; m_seq = m_seq + 16'd1;
        exp_q.push_back({1'b0, 8'hA5, 7'd0, m_drop, m_seq});
        exp_q.push_back({1'b0, dc[31:0]});
        exp_q.push_back({1'b0, dc[63:32]});
        exp_q.push_back({1'b0, di[31:0]});
        exp_q.push_back({1'b1, di[63:32]});
        m_drop = 0; m_base_cyc = c; m_base_inst = i;
        @(negedge clk);
        snap_req = 0; clear_base = 0;
    endtask

    task automatic collect(input int n, input bit toggle, output int busy_cyc, output bit stab);
        int got = 0, guard = 0;
        bit ph = 1, stalled = 0;
        logic [32:0] held = 0;
        busy_cyc = 0; stab = 1;
        while (got < n && guard < 200) begin
            out_ready = toggle ? ph : 1'b1; ph = !ph;
            if (busy) busy_cyc++;
            if (stalled && {out_last, out_data} !== held) stab = 0;
            stalled = out_valid && !out_ready;
            held = {out_last, out_data};
            if (out_valid && out_ready) begin rx.push_back({out_last, out_data}); got++; end
            guard++;
            @(negedge clk);
        end
        out_ready = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        repeat (2) @(negedge clk);
        n_cmp += 4;
        if (busy !== 0) begin n_bad++; $display("FAIL reset busy: got %b want 0", busy); end
        if (out_valid !== 0) begin n_bad++; $display("FAIL reset out_valid: got %b want 0", out_valid); end
        if (out_last !== 0) begin n_bad++; $display("FAIL reset out_last: got %b want 0", out_last); end
        if (out_data !== 0) begin n_bad++; $display("FAIL reset out_data: got %h want 0", out_data); end
        rst = 0; model_reset();
        @(negedge clk);
    endtask

    task automatic test_basic();
        snap(64'd100, 64'd40, 0);
        collect(5, 0, bc, stable);
        n_cmp++;
        if (bc !== 5) begin n_bad++; $display("FAIL basic busy_cycles: got %0d want 5", bc); end
        n_cmp++;
        if (out_valid !== 0 || busy !== 0) begin n_bad++; $display("FAIL basic idle_after: got v=%b b=%b want 0 0", out_valid, busy); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); a = rx.size() > 0 ? rx.pop_front() : 'x; n_cmp++;
            if (a !== e) begin n_bad++; $display("FAIL basic beat: got %h want %h", a, e); end
        end
    endtask

    task automatic test_second();
        snap(64'd250, 64'd90, 0);
        collect(5, 0, bc, stable);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); a = rx.size() > 0 ? rx.pop_front() : 'x; n_cmp++;
            if (a !== e) begin n_bad++; $display("FAIL second beat: got %h want %h", a, e); end
        end
    endtask

    task automatic test_stall();
        snap(64'h1_0000_0300, 64'h2_0000_0095, 0);
        cyc = 64'hDEAD; inst = 64'hBEEF;
        collect(5, 1, bc, stable);
        n_cmp++;
        if (stable !== 1) begin n_bad++; $display("FAIL stall hold: got unstable want stable"); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); a = rx.size() > 0 ? rx.pop_front() : 'x; n_cmp++;
            if (a !== e) begin n_bad++; $display("FAIL stall beat: got %h want %h", a, e); end
        end
    endtask

    task automatic test_drop();
        cyc = 64'd1000; inst = 64'd200; clear_base = 1;
        m_base_cyc = cyc; m_base_inst = inst;
        @(negedge clk);
        clear_base = 0;
        snap(64'd1010, 64'd203, 1);
        snap_req = 1; clear_base = 1; cyc = 64'd5000; inst = 64'd5000;
        @(negedge clk);
        snap_req = 0; clear_base = 0; m_drop = 1;
        collect(5, 0, bc, stable);
        snap(64'd1100, 64'd250, 0);
        collect(5, 0, bc, stable);
        snap(64'd1200, 64'd260, 0);
        collect(5, 0, bc, stable);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); a = rx.size() > 0 ? rx.pop_front() : 'x; n_cmp++;
            if (a !== e) begin n_bad++; $display("FAIL drop beat: got %h want %h", a, e); end
        end
    endtask

    task automatic test_wrap();
        cyc = 64'hFFFFFFFF_FFFFFFF0; inst = 64'd50; clear_base = 1;
        m_base_cyc = cyc; m_base_inst = inst;
        @(negedge clk);
        clear_base = 0;
        snap(64'h10, 64'd48, 0);
        collect(5, 0, bc, stable);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); a = rx.size() > 0 ? rx.pop_front() : 'x; n_cmp++;
            if (a !== e) begin n_bad++; $display("FAIL wrap beat: got %h want %h", a, e); end
        end
    endtask

    task automatic test_reset_mid();
        snap(64'd777, 64'd33, 0);
        out_ready = 1;
        repeat (2) @(negedge clk);
        rst = 1; out_ready = 0;
        #1;
        n_cmp += 2;
        if (out_valid !== 0) begin n_bad++; $display("FAIL rstmid out_valid: got %b want 0", out_valid); end
        if (busy !== 0) begin n_bad++; $display("FAIL rstmid busy: got %b want 0", busy); end
        @(negedge clk);
        rst = 0; model_reset(); out_ready = 1;
        repeat (3) begin
            @(negedge clk);
            n_cmp++;
            if (out_valid !== 0) begin n_bad++; $display("FAIL rstmid stray_beat: got %b want 0", out_valid); end
        end
        out_ready = 0;
        snap(64'd500, 64'd7, 0);
        collect(5, 0, bc, stable);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); a = rx.size() > 0 ? rx.pop_front() : 'x; n_cmp++;
            if (a !== e) begin n_bad++; $display("FAIL rstmid beat: got %h want %h", a, e); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_second();
        test_stall();
        test_drop();
        test_wrap();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
